// File: rtl/ddr5_ca_pkg.sv
// Shared encodings, FSM state type and frame packing helpers for the
// DDR5 PHY command/address generator.
package ddr5_ca_pkg;

  localparam logic [4:0] CA_CMD_MRW = 5'b00101;
  localparam logic [4:0] CA_CMD_RD  = 5'b01111;

  localparam logic [7:0] MR0  = 8'd0;
  localparam logic [7:0] MR8  = 8'd8;
  localparam logic [7:0] MR50 = 8'd50;

  typedef enum logic {
    CA_TYPE_MRW = 1'b0,
    CA_TYPE_RD  = 1'b1
  } ca_cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CA_A = 2'd1,
    ST_CA_B = 2'd2
  } ca_state_e;

  function automatic logic [13:0] ca_pack_a(input ca_cmd_type_e cmd_type, input logic [7:0] ma);
    logic [13:0] word;
    if (cmd_type == CA_TYPE_RD) begin
      word = {9'b0, CA_CMD_RD};
    end else begin
      word = {1'b0, ma, CA_CMD_MRW};
    end
    return word;
  endfunction

  function automatic logic [13:0] ca_pack_b(input logic [7:0] op);
    return {6'b0, op};
  endfunction

endpackage

// File: rtl/ddr5_phy_ca_init_seq.sv
// Power-up mode-register init step counter and MR/OP selection (MR0, MR8, MR50).
// Only instantiated when DDR5_CA_GEN_INIT_EN is defined.
module ddr5_phy_ca_init_seq
  import ddr5_ca_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       adv_i,
  input  logic [1:0] cfg_burst_length_i,
  input  logic [2:0] cfg_pre_cycle_i,
  input  logic       cfg_post_cycle_i,
  input  logic       cfg_crc_en_i,
  output logic [7:0] ma_o,
  output logic [7:0] op_o,
  output logic       all_issued_o
);

  logic [1:0] step_q;
  logic [1:0] step_d;
  logic [1:0] sel;

  // A start always issues step 0 in the same cycle, so the counter jumps to 1.
  assign sel = start_i ? 2'd0 : step_q;

  always_comb begin
    if (start_i) begin
      step_d = 2'd1;
    end else if (adv_i) begin
      step_d = step_q + 2'd1;
    end else begin
      step_d = step_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      step_q <= 2'd0;
    end else begin
      step_q <= step_d;
    end
  end

  always_comb begin
    case (sel)
      2'd0: begin
        ma_o = MR0;
        op_o = {6'b0, cfg_burst_length_i};
      end
      2'd1: begin
        ma_o = MR8;
        op_o = {cfg_post_cycle_i, 1'b0, cfg_pre_cycle_i, 3'b0};
      end
      2'd2: begin
        ma_o = MR50;
        op_o = {7'b0, cfg_crc_en_i};
      end
      default: begin
        ma_o = MR0;
        op_o = 8'h00;
      end
    endcase
  end

  assign all_issued_o = (step_q == 2'd3);

endmodule

// File: rtl/ddr5_phy_command_address_gen.sv
// Serialises MRW/READ requests into two-cycle DFI CA frames, with an optional
// MR0/MR8/MR50 power-up init sequence enabled by DDR5_CA_GEN_INIT_EN.
module ddr5_phy_command_address_gen
  import ddr5_ca_pkg::*;
#(
  parameter int pNUM_RANK = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           cfg_burst_length_i,
  input  logic [2:0]           cfg_pre_cycle_i,
  input  logic                 cfg_post_cycle_i,
  input  logic                 cfg_crc_en_i,
  input  logic                 init_start_i,
  output logic                 init_done_o,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_type_i,
  input  logic [7:0]           cmd_ma_i,
  input  logic [7:0]           cmd_op_i,
  input  logic [pNUM_RANK-1:0] cmd_cs_i,
  output logic [13:0]          dfi_address_o,
  output logic [pNUM_RANK-1:0] dfi_cs_o
);

`ifdef DDR5_CA_GEN_INIT_EN
  localparam logic INIT_DONE_RST = 1'b0;
`else
  localparam logic INIT_DONE_RST = 1'b1;
`endif

  ca_state_e             state_q, state_d;
  logic [13:0]           addr_q, addr_d;
  logic [pNUM_RANK-1:0]  cs_q, cs_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  init_act_q, init_act_d;
  logic [7:0]            op_q, op_d;

  logic                  start_ok;
  logic                  init_avail;
  logic                  init_all;
  logic                  init_go;
  logic                  accept;
  logic                  finish;
  logic [7:0]            init_ma;
  logic [7:0]            init_op;

`ifdef DDR5_CA_GEN_INIT_EN
  assign start_ok   = init_start_i & enable_i & (state_q == ST_IDLE);
  assign init_avail = start_ok | (init_act_q & ~init_all);

  ddr5_phy_ca_init_seq u_init_seq (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_ok),
    .adv_i              (init_go),
    .cfg_burst_length_i (cfg_burst_length_i),
    .cfg_pre_cycle_i    (cfg_pre_cycle_i),
    .cfg_post_cycle_i   (cfg_post_cycle_i),
    .cfg_crc_en_i       (cfg_crc_en_i),
    .ma_o               (init_ma),
    .op_o               (init_op),
    .all_issued_o       (init_all)
  );
`else
  logic unused_init_inputs;
  assign unused_init_inputs = ^{init_start_i, cfg_burst_length_i, cfg_pre_cycle_i,
                                cfg_post_cycle_i, cfg_crc_en_i};
  assign start_ok   = 1'b0;
  assign init_avail = 1'b0;
  assign init_all   = 1'b0;
  assign init_ma    = 8'h00;
  assign init_op    = 8'h00;
`endif

  // Init always outranks a host command presented in the same cycle.
  assign accept = cmd_valid_i & ready_q & enable_i & ~start_ok;
  assign finish = init_act_q & init_all & (state_q == ST_CA_B);

  always_comb begin
    state_d    = state_q;
    addr_d     = 14'h0000;
    cs_d       = {pNUM_RANK{1'b1}};
    op_d       = op_q;
    init_act_d = init_act_q;
    done_d     = done_q;
    init_go    = 1'b0;
    case (state_q)
      ST_IDLE, ST_CA_B: begin
        if (enable_i && init_avail) begin
          state_d    = ST_CA_A;
          init_go    = 1'b1;
          addr_d     = ca_pack_a(CA_TYPE_MRW, init_ma);
          cs_d       = {pNUM_RANK{1'b0}};
          op_d       = init_op;
          init_act_d = 1'b1;
          done_d     = 1'b0;
        end else if (accept) begin
          state_d = ST_CA_A;
          addr_d  = ca_pack_a(ca_cmd_type_e'(cmd_type_i), cmd_ma_i);
          cs_d    = cmd_cs_i;
          op_d    = cmd_op_i;
        end else begin
          state_d = ST_IDLE;
          if (finish) begin
            init_act_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            init_act_d = init_act_q;
          end
        end
      end
      ST_CA_A: begin
        state_d = ST_CA_B;
        addr_d  = ca_pack_b(op_q);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = enable_i & done_d & ~init_act_d &
              ((state_d == ST_IDLE) || (state_d == ST_CA_B));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= 14'h0000;
      cs_q       <= {pNUM_RANK{1'b1}};
      ready_q    <= 1'b0;
      done_q     <= INIT_DONE_RST;
      init_act_q <= 1'b0;
      op_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      init_act_q <= init_act_d;
      op_q       <= op_d;
    end
  end

  assign dfi_address_o = addr_q;
  assign dfi_cs_o      = cs_q;
  assign cmd_ready_o   = ready_q;
  assign init_done_o   = done_q;

endmodule

// File: doc/ddr5_phy_command_address_gen.md
# ddr5_phy_command_address_gen

Transmit-side command/address generator for the DDR5 PHY. Serialises MRW and READ requests into two-cycle DFI command frames on `dfi_address_o`/`dfi_cs_o`, the same frames the PHY's command/address snooper decodes. It optionally runs a power-up mode-register initialisation sequence (MR0, MR8, MR50) from static configuration inputs. Sits between the controller-side command queue and the DFI CA pins.

## Interface
- `pNUM_RANK`, 1, number of chip-select ranks
- `clk_i` input 1: DFI clock
- `rst_i` input 1: asynchronous, active-low reset
- `enable_i` input 1: block enable; low holds the block idle after the current frame
- `cfg_burst_length_i` input 2: MR0 OP[1:0] for init
- `cfg_pre_cycle_i` input 3: MR8 OP[5:3] (read preamble) for init
- `cfg_post_cycle_i` input 1: MR8 OP[7] (read postamble) for init
- `cfg_crc_en_i` input 1: MR50 OP[0] for init
- `init_start_i` input 1: single-cycle pulse that starts the init sequence
- `init_done_o` output 1: init sequence complete
- `cmd_valid_i` input 1: host command valid
- `cmd_ready_o` output 1: host command accepted when valid & ready
- `cmd_type_i` input 1: 0 = MRW, 1 = READ
- `cmd_ma_i` input 8: MR address (MRW only)
- `cmd_op_i` input 8: MRW opcode, or READ column byte
- `cmd_cs_i` input pNUM_RANK: active-low rank select for the command
- `dfi_address_o` output 14: DFI CA
- `dfi_cs_o` output pNUM_RANK: DFI chip select, active low

## Operation
- Frame encoding:
  - Cycle A drives `dfi_cs_o` = rank mask (low).
    - MRW: `dfi_address_o` = {1'b0, MA[7:0], 5'b00101}.
    - READ: `dfi_address_o` = {9'b0, 5'b01111}.
  - Cycle B drives `dfi_cs_o` all-high and `dfi_address_o` = {6'b0, OP[7:0]}.
- Idle output: `dfi_cs_o` = all ones, `dfi_address_o` = 0.
- FSM states:
  - IDLE to CA_A when a command is accepted or an init step is pending.
  - CA_A to CA_B unconditionally.
  - CA_B to CA_A when another command or init step is pending; otherwise CA_B to IDLE.
- `cmd_ready_o` = `enable_i` & `init_done_o` & `!init_active` & (state is IDLE or CA_B). Back-to-back commands therefore produce gap-free frames.
- Command fields are captured into a holding register on acceptance. Inputs are don't-care afterwards.
- Init sequence:
  - `init_start_i` is honoured only in IDLE with `enable_i` high. In any other state it is ignored.
  - It clears `init_done_o` and issues three MRW frames to all ranks (cs all low), in this order:
    - MR0 with OP = {6'b0, cfg_burst_length_i}
    - MR8 with OP = {cfg_post_cycle_i, 1'b0, cfg_pre_cycle_i, 3'b0}
    - MR50 with OP = {7'b0, cfg_crc_en_i}
  - `cfg_*` inputs are sampled when each step's CA_A is entered.
  - `init_done_o` rises in the cycle after the last CA_B.
- Init has priority. Host commands are blocked while init is active.
- `enable_i` low: the current frame (both cycles) completes, then the FSM holds in IDLE and `cmd_ready_o` stays low.
  - An init sequence in progress pauses between frames and resumes when `enable_i` returns high. It is never aborted.

## Timing
- Reset values:
  - `dfi_cs_o` all ones
  - `dfi_address_o` 0
  - `cmd_ready_o` 0
  - `init_done_o` 0 with the init macro, 1 without it
  - FSM in IDLE, init index 0
- Reset asserted mid-frame returns outputs to idle values immediately (asynchronous).
- Latency:
  - Command accepted at edge N: cycle A appears after edge N and cycle B after edge N+1.
  - Max throughput is one command per 2 cycles.
- All outputs are registered.
- `init_start_i` arriving in the same cycle as `cmd_valid_i`: init wins and the command is not accepted.

## Configuration
- `DDR5_CA_GEN_INIT_EN` defined: init sequencer and `cfg_*` datapath are present.
- Undefined:
  - `init_done_o` tied to 1.
  - `init_start_i` and `cfg_*` are ignored.
  - FSM is driven by the host path only.

## Structure
- Package `ddr5_ca_pkg` holds:
  - CMD codes `CA_CMD_MRW` = 5'b00101 and `CA_CMD_RD` = 5'b01111
  - MR address constants `MR0`/`MR8`/`MR50` (0/8/50)
  - enum `ca_cmd_type_e`
  - FSM state enum
  - pack functions building cycle-A and cycle-B words
- Sub-module `ddr5_phy_ca_init_seq`: 2-bit step counter plus MR/OP mux, instantiated only under `DDR5_CA_GEN_INIT_EN`.

## Test plan
- Single MRW, MA=8, OP=8'h08, rank mask 0 -> cycle A: address 14'b00000100000101 with cs 0; cycle B: address 14'h0008 with cs 1; then idle.
- Back-to-back MRW MR50 OP=1 followed by READ OP=8'h00 -> four consecutive frame cycles with no gap; READ cycle A address = 14'b00000000001111.
- Init with BL=2'b10, pre=3'b011, post=1, crc=1 -> three frames carrying OP bytes 8'h02, 8'h98, 8'h01 to MR0/MR8/MR50; `init_done_o` rises one cycle after the final cycle B; `cmd_ready_o` stays low throughout.
- `enable_i` dropped during cycle A -> cycle B still driven, then idle with ready 0; re-enable resumes service.
- Reset asserted during cycle B -> cs all ones and address 0 immediately; `cmd_ready_o` 0; `init_done_o` 0 (macro builds).
- `init_start_i` and `cmd_valid_i` asserted together in IDLE -> MR0 frame issued first; host command accepted only after `init_done_o` = 1.
